// File: rtl/resp_track_block.sv
// resp_track_block: routes one master's requests to N_SLAVE slaves and
// returns the slave responses to the master strictly in request order.
// An in-order FIFO of target slave indices decides which slave may answer
// next; anything else is dropped and latched in err_unexp_o.
// Optional feature macro: RESP_TRACK_PIPE_EN (registered response path,
// one extra cycle of latency; default is a combinational response path).

// Per-slave slice: request decode, grant contribution, head match and
// unexpected-response detection for slave index K.
module resp_track_lane #(
  parameter int ROUT_WIDTH = 3,
  parameter int K          = 0,
  parameter bit SINGLE     = 1'b0
) (
  input  logic                  req,
  input  logic [ROUT_WIDTH-1:0] addr,
  input  logic                  full,
  input  logic [ROUT_WIDTH-1:0] head,
  input  logic                  empty,
  input  logic                  gnt_i,
  input  logic                  valid_i,
  output logic                  req_o,
  output logic                  gnt_hit,
  output logic                  head_sel,
  output logic                  pop_hit,
  output logic                  unexp
);
  logic addr_hit;

  // With a single slave the routing address carries no information.
  generate
    if (SINGLE) begin : g_single
      assign addr_hit = 1'b1;
      assign head_sel = 1'b1;
    end else begin : g_multi
      assign addr_hit = (addr == ROUT_WIDTH'(K));
      assign head_sel = (head == ROUT_WIDTH'(K));
    end
  endgenerate

  assign req_o   = req & addr_hit & ~full;
  assign gnt_hit = req_o & gnt_i;
  // Response checks use the FIFO state before any same-cycle push.
  assign pop_hit = ~empty & head_sel & valid_i;
  assign unexp   = valid_i & (empty | ~head_sel);
endmodule

module resp_track_block #(
  parameter int ID              = 1,
  parameter int ID_WIDTH        = 20,
  parameter int N_SLAVE         = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int ROUT_WIDTH     = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               data_req_i,
  input  logic [ROUT_WIDTH-1:0]              routing_addr_i,
  output logic                               data_gnt_o,
  output logic [N_SLAVE-1:0]                 data_req_o,
  input  logic [N_SLAVE-1:0]                 data_gnt_i,
  output logic [ID_WIDTH-1:0]                data_ID_o,
  input  logic [N_SLAVE-1:0]                 data_r_valid_i,
  input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0] data_r_rdata_i,
  output logic                               data_r_valid_o,
  output logic [DATA_WIDTH-1:0]              data_r_rdata_o,
  output logic [CNT_WIDTH-1:0]               outstanding_o,
  output logic                               err_unexp_o
);
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [ROUT_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0]  wptr_q, rptr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  err_q;

  logic                  full, empty, push, pop;
  logic [ROUT_WIDTH-1:0] head;
  logic [N_SLAVE-1:0]    gnt_hit, head_sel, pop_hit, unexp;
  logic [DATA_WIDTH-1:0] head_data;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // One slice per slave port.
  genvar k;
  generate
    for (k = 0; k < N_SLAVE; k++) begin : g_lane
      resp_track_lane #(
        .ROUT_WIDTH (ROUT_WIDTH),
        .K          (k),
        .SINGLE     (N_SLAVE == 1)
      ) u_lane (
        .req      (data_req_i),
        .addr     (routing_addr_i),
        .full     (full),
        .head     (head),
        .empty    (empty),
        .gnt_i    (data_gnt_i[k]),
        .valid_i  (data_r_valid_i[k]),
        .req_o    (data_req_o[k]),
        .gnt_hit  (gnt_hit[k]),
        .head_sel (head_sel[k]),
        .pop_hit  (pop_hit[k]),
        .unexp    (unexp[k])
      );
    end
  endgenerate

  // Out-of-range addresses match no lane, so they get neither request nor grant.
  assign data_gnt_o  = |gnt_hit;
  assign push        = data_req_i & data_gnt_o;
  assign pop         = |pop_hit;
  assign data_ID_o   = ID_WIDTH'(1) << ID;
  assign outstanding_o = cnt_q;
  assign err_unexp_o   = err_q;

  // Head-slave data select; head_sel is one-hot so an OR-reduce suffices.
  always_comb begin
    head_data = '0;
    for (int i = 0; i < N_SLAVE; i++)
      if (head_sel[i]) head_data = head_data | data_r_rdata_i[i];
  end

  // Tracking FIFO storage; contents are only meaningful below cnt_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= routing_addr_i;
  end

  // Pointers, outstanding count and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (|unexp) err_q <= 1'b1;
    end
  end

`ifdef RESP_TRACK_PIPE_EN
  logic [1:0]            vld_pipe;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign vld_pipe[0] = pop;

  // Registered response path: one cycle behind the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      rdata_q     <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (pop) rdata_q <= head_data;
    end
  end

  assign data_r_valid_o = vld_pipe[1];
  assign data_r_rdata_o = rdata_q;
`else
  // Combinational path: the head mux is visible whenever something is
  // outstanding, and reads as zero while the FIFO is empty (incl. reset).
  assign data_r_valid_o = pop;
  assign data_r_rdata_o = empty ? '0 : head_data;
`endif

  // Structural invariants of the tracker.
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_FULL);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_req_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(data_req_o));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: tb/tb_resp_track_block.sv
// Bench for resp_track_block: two instances (8 slaves / depth 4 and
// 1 slave / depth 3), a decode vector table, directed corner sequences and
// per-instance scoreboards of expected response data.
module tb_resp_track_block;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: ID=1, ID_WIDTH=20, 8 slaves, depth 4
  logic             req_a;
  logic [2:0]       addr_a;
  logic             gnt_o_a;
  logic [7:0]       req_o_a, gnt_i_a, valid_i_a;
  logic [19:0]      id_a;
  logic [7:0][31:0] rdata_i_a;
  logic             valid_o_a;
  logic [31:0]      rdata_o_a;
  logic [2:0]       out_a;
  logic             err_a;

  resp_track_block #(.ID(1), .ID_WIDTH(20), .N_SLAVE(8), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) u_a (
    .clk(clk), .rst_n(rst_n), .data_req_i(req_a), .routing_addr_i(addr_a),
    .data_gnt_o(gnt_o_a), .data_req_o(req_o_a), .data_gnt_i(gnt_i_a), .data_ID_o(id_a),
    .data_r_valid_i(valid_i_a), .data_r_rdata_i(rdata_i_a), .data_r_valid_o(valid_o_a),
    .data_r_rdata_o(rdata_o_a), .outstanding_o(out_a), .err_unexp_o(err_a));

  // Instance B: ID=0, ID_WIDTH=4, 1 slave, depth 3
  logic             req_b;
  logic [0:0]       addr_b;
  logic             gnt_o_b;
  logic [0:0]       req_o_b, gnt_i_b, valid_i_b;
  logic [3:0]       id_b;
  logic [0:0][31:0] rdata_i_b;
  logic             valid_o_b;
  logic [31:0]      rdata_o_b;
  logic [1:0]       out_b;
  logic             err_b;

  resp_track_block #(.ID(0), .ID_WIDTH(4), .N_SLAVE(1), .DATA_WIDTH(32), .MAX_OUTSTANDING(3)) u_b (
    .clk(clk), .rst_n(rst_n), .data_req_i(req_b), .routing_addr_i(addr_b),
    .data_gnt_o(gnt_o_b), .data_req_o(req_o_b), .data_gnt_i(gnt_i_b), .data_ID_o(id_b),
    .data_r_valid_i(valid_i_b), .data_r_rdata_i(rdata_i_b), .data_r_valid_o(valid_o_b),
    .data_r_rdata_o(rdata_o_b), .outstanding_o(out_b), .err_unexp_o(err_b));

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards: every forwarded response must match the oldest expected one.
  always @(negedge clk) begin
    if (valid_o_a === 1'b1) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL resp_a_unexpected: got 0x%0h, want no response", rdata_o_a);
      end else begin
        logic [31:0] e;
        e = q_a.pop_front();
        if (rdata_o_a !== e) begin
          errors++;
          $display("FAIL resp_a_data: got 0x%0h, want 0x%0h", rdata_o_a, e);
        end
      end
    end
    if (valid_o_b === 1'b1) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL resp_b_unexpected: got 0x%0h, want no response", rdata_o_b);
      end else begin
        logic [31:0] e;
        e = q_b.pop_front();
        if (rdata_o_b !== e) begin
          errors++;
          $display("FAIL resp_b_data: got 0x%0h, want 0x%0h", rdata_o_b, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    req_a = 1'b0; gnt_i_a = '0; valid_i_a = '0;
  endtask

  task automatic idle_b();
    req_b = 1'b0; gnt_i_b = '0; valid_i_b = '0;
  endtask

  task automatic resp_a(input int s, input logic [31:0] d, input bit expect_fwd);
    valid_i_a    = 8'(1 << s);
    rdata_i_a[s] = d;
    if (expect_fwd) q_a.push_back(d);
  endtask

  task automatic resp_b(input logic [31:0] d);
    valid_i_b    = 1'b1;
    rdata_i_b[0] = d;
    q_b.push_back(d);
  endtask

  task automatic req_to_a(input int s);
    req_a = 1'b1; addr_a = 3'(s); gnt_i_a = 8'hFF;
  endtask

  typedef struct {
    logic        req;
    logic [2:0]  addr;
    logic [7:0]  gnt;
    logic [31:0] data;
    logic [7:0]  exp_req;
    logic        exp_gnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 3'd3, 8'h08, 32'hCAFE0001, 8'h08, 1'b1};
    vecs[1] = '{1'b0, 3'd3, 8'hFF, 32'h0,        8'h00, 1'b0};
    vecs[2] = '{1'b1, 3'd5, 8'hDF, 32'h0,        8'h20, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 8'h01, 32'h12345678, 8'h01, 1'b1};
    vecs[4] = '{1'b1, 3'd7, 8'h80, 32'hA5A50007, 8'h80, 1'b1};
    vecs[5] = '{1'b1, 3'd6, 8'hBF, 32'h0,        8'h40, 1'b0};

    rst_n = 1'b0;
    idle_a(); addr_a = '0; rdata_i_a = '0;
    idle_b(); addr_b = '0; rdata_i_b = '0;
    #3;
    chk("rst_out_a", out_a, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_valid_a", valid_o_a, 0);
    chk("rst_rdata_a", rdata_o_a, 0);
    chk("id_a", id_a, 20'h00002);
    chk("id_b", id_b, 4'b0001);
    cyc(); rst_n = 1'b1;

    // Decode table on an empty tracker; granted ones are answered next cycle
    for (int i = 0; i < 6; i++) begin
      cyc();
      req_a = vecs[i].req; addr_a = vecs[i].addr; gnt_i_a = vecs[i].gnt; valid_i_a = '0;
      #1;
      chk($sformatf("vec%0d_req_o", i), req_o_a, vecs[i].exp_req);
      chk($sformatf("vec%0d_gnt_o", i), gnt_o_a, vecs[i].exp_gnt);
      if (vecs[i].exp_gnt) begin
        cyc(); idle_a(); resp_a(vecs[i].addr, vecs[i].data, 1);
        #1 chk($sformatf("vec%0d_out1", i), out_a, 1);
        cyc(); idle_a();
        #1 chk($sformatf("vec%0d_out0", i), out_a, 0);
      end
    end

    // Fill to depth 4, then a fifth request must be blocked
    for (int i = 0; i < 4; i++) begin
      cyc(); req_to_a(i);
      #1 chk($sformatf("fill_gnt%0d", i), gnt_o_a, 1);
    end
    cyc(); req_to_a(4);
    #1;
    chk("fill_out4", out_a, 4);
    chk("fill_gnt_blocked", gnt_o_a, 0);
    chk("fill_req_blocked", req_o_a, 0);
    resp_a(0, 32'h0000F000, 1);
    #1;
    chk("full_pop_no_bypass_gnt", gnt_o_a, 0);
    chk("full_pop_no_bypass_req", req_o_a, 0);
    cyc(); valid_i_a = '0;
    #1;
    chk("fill_out3", out_a, 3);
    chk("fill_gnt_reenabled", gnt_o_a, 1);
    chk("fill_req_reenabled", req_o_a, 8'h10);
    cyc(); req_a = 1'b0; resp_a(1, 32'h0000F001, 1);
    #1 chk("fill_out_refill", out_a, 4);
    cyc(); resp_a(2, 32'h0000F002, 1);
    cyc(); resp_a(3, 32'h0000F003, 1);
    cyc(); resp_a(4, 32'h0000F004, 1);
    cyc(); idle_a();
    #1 chk("fill_drained", out_a, 0);

    // Simultaneous push and pop at count 2
    cyc(); req_to_a(5);
    cyc(); req_to_a(6);
    cyc(); req_to_a(7); resp_a(5, 32'h5555AAAA, 1);
    #1 chk("simul_out_before", out_a, 2);
    chk("simul_gnt", gnt_o_a, 1);
    cyc(); req_a = 1'b0; resp_a(6, 32'h6666BBBB, 1);
    #1 chk("simul_out_after", out_a, 2);
    cyc(); resp_a(7, 32'h7777CCCC, 1);
    cyc(); idle_a();
    #1 chk("simul_drained", out_a, 0);
    chk("err_clean_so_far", err_a, 0);

    // Out-of-order response is dropped and flagged
    cyc(); req_to_a(2);
    cyc(); req_to_a(5);
    cyc(); idle_a(); resp_a(5, 32'hBAD00005, 0);
    #1 chk("order_err_pre", err_a, 0);
    cyc(); resp_a(2, 32'h22220002, 1);
    #1 chk("order_err_set", err_a, 1);
    chk("order_out2", out_a, 2);
    cyc(); resp_a(5, 32'h55550005, 1);
    #1 chk("order_out1", out_a, 1);
    cyc(); idle_a();
    #1 chk("order_out0", out_a, 0);
    chk("order_err_sticky", err_a, 1);

    // Reset with 3 outstanding, then a late response
    cyc(); req_to_a(1);
    cyc(); req_to_a(2);
    cyc(); req_to_a(3);
    cyc(); idle_a();
    #1 chk("rst_mid_out3", out_a, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", out_a, 0);
    chk("rst_mid_err", err_a, 0);
    chk("rst_mid_valid", valid_o_a, 0);
    chk("rst_mid_rdata", rdata_o_a, 0);
    chk("rst_mid_req_o", req_o_a, 0);
    chk("rst_mid_gnt_o", gnt_o_a, 0);
    cyc(); rst_n = 1'b1;
    cyc(); resp_a(1, 32'hDEAD0001, 0);
    #1 chk("late_out", out_a, 0);
    cyc(); idle_a();
    #1 chk("late_err", err_a, 1);
    chk("late_out_after", out_a, 0);

    // Response in the grant cycle of an empty tracker is unexpected
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); req_to_a(1); resp_a(1, 32'hDEAD0017, 0);
    #1 chk("samecyc_gnt", gnt_o_a, 1);
    cyc(); idle_a();
    #1 chk("samecyc_err", err_a, 1);
    chk("samecyc_out", out_a, 1);
    resp_a(1, 32'h11110017, 1);
    cyc(); idle_a();
    #1 chk("samecyc_out0", out_a, 0);

    // Single slave, depth 3: address ignored, fill and wrap
    for (int i = 0; i < 3; i++) begin
      cyc(); req_b = 1'b1; addr_b = 1'(i); gnt_i_b = 1'b1;
      #1 chk($sformatf("b_fill_gnt%0d", i), gnt_o_b, 1);
      chk($sformatf("b_fill_req%0d", i), req_o_b, 1);
    end
    cyc(); addr_b = 1'b1;
    #1 chk("b_full_out", out_b, 3);
    chk("b_full_gnt", gnt_o_b, 0);
    chk("b_full_req", req_o_b, 0);
    cyc(); req_b = 1'b0; resp_b(32'hB0000100);
    cyc(); resp_b(32'hB0000101);
    cyc(); resp_b(32'hB0000102);
    cyc(); idle_b();
    #1 chk("b_drained", out_b, 0);
    for (int t = 0; t < 7; t++) begin
      cyc(); req_b = 1'b1; addr_b = 1'(t); gnt_i_b = 1'b1; valid_i_b = '0;
      #1 chk($sformatf("b_wrap_gnt%0d", t), gnt_o_b, 1);
      cyc(); req_b = 1'b0; resp_b(32'hB0000000 + 32'(t));
      #1 chk($sformatf("b_wrap_out%0d", t), out_b, 1);
    end
    cyc(); idle_b();
    #1 chk("b_wrap_out0", out_b, 0);
    chk("b_err", err_b, 0);

    repeat (3) cyc();
    chk("sb_a_empty", q_a.size(), 0);
    chk("sb_b_empty", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
